// File: rtl/tm1638_device_responder.sv
// Device side of the TM1638 STB/CLK/DIO link. It decodes controller frames into
// display-RAM writes and display control, and shifts the key-scan snapshot back out on DIO.
module tm1638_device_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int KEY_BYTES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb_i,
  input  logic        sclk_i,
  input  logic        dio_i,
  output logic        dio_o,
  output logic        dio_oe,
  input  logic [31:0] key_scan_i,
  output logic        ram_we,
  output logic [3:0]  ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        disp_on,
  output logic [2:0]  brightness,
  output logic        frame_err
);
  localparam logic [5:0] KEY_BITS = 6'(KEY_BYTES * 8);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_READ, S_SKIP} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] dio_sync_q, dio_sync_d;
  logic stb_prev_q, sclk_prev_q;

  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [3:0]  addr_q, addr_d;
  logic        fixed_q, fixed_d;
  logic [31:0] snap_q, snap_d;
  logic [5:0]  rd_idx_q, rd_idx_d;
  logic        dio_o_q, dio_o_d, dio_oe_q, dio_oe_d;
  logic        ram_we_q, ram_we_d;
  logic [3:0]  ram_addr_q, ram_addr_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        disp_on_q, disp_on_d;
  logic [2:0]  brightness_q, brightness_d;
  logic        frame_err_q, frame_err_d;

  logic stb_s, sclk_s, dio_s;
  logic stb_fall, stb_rise, sclk_rise, sclk_fall;
  logic in_frame, shift_en, byte_done;
  logic [7:0] new_byte;

  assign stb_s     = stb_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign dio_s     = dio_sync_q[SYNC_STAGES-1];
  assign stb_fall  = stb_prev_q & ~stb_s;
  assign stb_rise  = ~stb_prev_q & stb_s;
  assign in_frame  = (state_q != S_IDLE);
  assign sclk_rise = ~sclk_prev_q & sclk_s & ~stb_s & in_frame;
  assign sclk_fall = sclk_prev_q & ~sclk_s & ~stb_s & in_frame;
  assign shift_en  = sclk_rise & (state_q != S_READ);
  assign byte_done = shift_en & (bit_cnt_q == 3'd7);
  assign new_byte  = {dio_s, sh_q[7:1]};

  always_comb begin
    stb_sync_d  = {stb_sync_q[SYNC_STAGES-2:0], stb_i};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
    dio_sync_d  = {dio_sync_q[SYNC_STAGES-2:0], dio_i};
  end

  // State register. The stb chain resets low so a pin held low through reset
  // never looks like a falling edge; a fresh frame needs STB high, then low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      stb_sync_q   <= '0;
      sclk_sync_q  <= '0;
      dio_sync_q   <= '1;
      stb_prev_q   <= 1'b0;
      sclk_prev_q  <= 1'b0;
      bit_cnt_q    <= '0;
      sh_q         <= '0;
      addr_q       <= '0;
      fixed_q      <= 1'b0;
      snap_q       <= '0;
      rd_idx_q     <= '0;
      dio_o_q      <= 1'b1;
      dio_oe_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      disp_on_q    <= 1'b0;
      brightness_q <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      stb_sync_q   <= stb_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      dio_sync_q   <= dio_sync_d;
      stb_prev_q   <= stb_s;
      sclk_prev_q  <= sclk_s;
      bit_cnt_q    <= bit_cnt_d;
      sh_q         <= sh_d;
      addr_q       <= addr_d;
      fixed_q      <= fixed_d;
      snap_q       <= snap_d;
      rd_idx_q     <= rd_idx_d;
      dio_o_q      <= dio_o_d;
      dio_oe_q     <= dio_oe_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      disp_on_q    <= disp_on_d;
      brightness_q <= brightness_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (stb_fall) state_d = S_CMD;
      S_CMD: begin
        if (byte_done) begin
          case (new_byte[7:6])
            2'b01:   state_d = new_byte[1] ? S_READ : S_SKIP;
            2'b11:   state_d = S_WDATA;
            default: state_d = S_SKIP;
          endcase
        end
      end
      default: ;
    endcase
    if (stb_rise && in_frame) state_d = S_IDLE;
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    sh_d         = sh_q;
    addr_d       = addr_q;
    fixed_d      = fixed_q;
    snap_d       = snap_q;
    rd_idx_d     = rd_idx_q;
    dio_o_d      = dio_o_q;
    dio_oe_d     = dio_oe_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    disp_on_d    = disp_on_q;
    brightness_d = brightness_q;
    frame_err_d  = 1'b0;

    if (stb_fall && !in_frame) bit_cnt_d = '0;
    if (shift_en) begin
      sh_d      = new_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    if (byte_done) begin
      if (state_q == S_CMD) begin
        case (new_byte[7:6])
          2'b01: begin
            fixed_d = new_byte[2];
            if (new_byte[1]) begin
              snap_d   = key_scan_i;
              rd_idx_d = '0;
            end
          end
          2'b10: begin
            disp_on_d    = new_byte[3];
            brightness_d = new_byte[2:0];
          end
          2'b11:   addr_d = new_byte[3:0];
          default: frame_err_d = 1'b1;
        endcase
      end else if (state_q == S_WDATA) begin
        ram_we_d    = 1'b1;
        ram_addr_d  = addr_q;
        ram_wdata_d = new_byte;
        if (!fixed_q) addr_d = addr_q + 4'd1;
      end
    end

    // Key bits go out on falling edges so the controller samples them on the rise.
    if (sclk_fall && state_q == S_READ) begin
      if (rd_idx_q < KEY_BITS) begin
        dio_o_d  = snap_q[rd_idx_q[4:0]];
        dio_oe_d = 1'b1;
        rd_idx_d = rd_idx_q + 6'd1;
      end else begin
        dio_o_d  = 1'b1;
        dio_oe_d = 1'b0;
      end
    end

    if (stb_rise && in_frame) begin
      dio_o_d  = 1'b1;
      dio_oe_d = 1'b0;
      if (bit_cnt_d != 3'd0) frame_err_d = 1'b1;
      bit_cnt_d = '0;
    end
  end

  assign dio_o      = dio_o_q;
  assign dio_oe     = dio_oe_q & ~stb_rise;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign disp_on    = disp_on_q;
  assign brightness = brightness_q;
  assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_tm1638_device_responder.sv
// Bench for tm1638_device_responder: bit-banged controller frames, expected
// RAM writes and key bytes held in queues and checked as the DUT produces them.
module tb_tm1638_device_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb_i = 1'b1, sclk_i = 1'b1, dio_i = 1'b1;
  logic [31:0] key_scan_i = '0;
  logic        dio_o, dio_oe, ram_we, disp_on, frame_err;
  logic [3:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [2:0]  brightness;

  typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;
  wr_t        wq[$];
  logic [7:0] kq[$];
  int errs = 0, checks = 0, err_pulses = 0, exp_err = 0;

  tm1638_device_responder #(.SYNC_STAGES(2), .KEY_BYTES(4)) dut (
    .clk(clk), .rst(rst), .stb_i(stb_i), .sclk_i(sclk_i), .dio_i(dio_i),
    .dio_o(dio_o), .dio_oe(dio_oe), .key_scan_i(key_scan_i),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .disp_on(disp_on), .brightness(brightness), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (frame_err) err_pulses++;
    if (ram_we) begin
      if (wq.size() == 0) chk("unexpected_we", wq.size(), 1);
      else begin
        e = wq.pop_front();
        chk("we_addr", ram_addr, e.a);
        chk("we_data", ram_wdata, e.d);
      end
    end
  end

  task automatic wait_clk(input int n); repeat (n) @(negedge clk); endtask
  task automatic bit_out(input logic b);
    sclk_i = 1'b0; dio_i = b; wait_clk(5);
    sclk_i = 1'b1; wait_clk(5);
  endtask
  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
  endtask
  task automatic stb_low;  stb_i = 1'b0; wait_clk(5); endtask
  task automatic stb_high; dio_i = 1'b1; stb_i = 1'b1; wait_clk(6); endtask
  task automatic frame1(input logic [7:0] b); stb_low(); send_byte(b); stb_high(); endtask
  task automatic frame3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    stb_low(); send_byte(b0); send_byte(b1); send_byte(b2); stb_high();
  endtask
  task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
    wr_t e; e.a = a; e.d = d; wq.push_back(e);
  endtask
  task automatic chk_idle_state(input string tag);
    chk({tag, "_wq"}, wq.size(), 0);
    chk({tag, "_err"}, err_pulses, exp_err);
  endtask

  task automatic read_bytes(input int nbytes);
    logic [7:0] got;
    for (int j = 0; j < nbytes; j++) begin
      for (int i = 0; i < 8; i++) begin
        sclk_i = 1'b0; wait_clk(5);
        chk("key_oe", dio_oe, 1);
        got[i] = dio_o;
        sclk_i = 1'b1; wait_clk(5);
      end
      chk("key_byte", got, kq.pop_front());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wait_clk(4);
    chk("rst_oe", dio_oe, 0);    chk("rst_dio", dio_o, 1);
    chk("rst_we", ram_we, 0);    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0); chk("rst_disp", disp_on, 0);
    chk("rst_bri", brightness, 0);  chk("rst_ferr", frame_err, 0);
    rst = 1'b0; wait_clk(6);

    // auto-increment writes
    frame1(8'h40);
    push_wr(4'd0, 8'h3F); push_wr(4'd1, 8'h06);
    frame3(8'hC0, 8'h3F, 8'h06);
    chk_idle_state("t1");

    // fixed address, then auto-increment across the 15 -> 0 wrap
    frame1(8'h44);
    push_wr(4'd15, 8'h11); push_wr(4'd15, 8'h22);
    frame3(8'hCF, 8'h11, 8'h22);
    frame1(8'h40);
    push_wr(4'd15, 8'h11); push_wr(4'd0, 8'h22);
    frame3(8'hCF, 8'h11, 8'h22);
    chk_idle_state("t2");

    // display control
    frame1(8'h8C);
    chk("disp_on_8c", disp_on, 1); chk("bri_8c", brightness, 4);
    frame1(8'h80);
    chk("disp_on_80", disp_on, 0); chk("bri_80", brightness, 0);
    // bytes after a non-address command do not write
    frame3(8'h8B, 8'h55, 8'hAA);
    chk("disp_on_8b", disp_on, 1); chk("bri_8b", brightness, 3);
    chk_idle_state("t3");

    // key read, full 32 bits then oe drops on the following fall
    key_scan_i = 32'hA55A_0FF0;
    kq.push_back(8'hF0); kq.push_back(8'h0F); kq.push_back(8'h5A); kq.push_back(8'hA5);
    stb_low(); send_byte(8'h42);
    key_scan_i = 32'h1234_5678;   // snapshot must already be taken
    read_bytes(4);
    sclk_i = 1'b0; wait_clk(5);
    chk("oe_after_bit31", dio_oe, 0);
    sclk_i = 1'b1; wait_clk(5);
    stb_high();
    chk("oe_after_stb", dio_oe, 0);
    // oe released by STB rise mid-read
    kq.push_back(8'h78);
    stb_low(); send_byte(8'h42); read_bytes(1);
    sclk_i = 1'b0; wait_clk(5);
    chk("oe_mid_read", dio_oe, 1);
    stb_i = 1'b1; wait_clk(6);
    chk("oe_stb_rise", dio_oe, 0);
    sclk_i = 1'b1; wait_clk(4);
    chk_idle_state("t4");

    // partial byte at STB rise, then unknown command
    stb_low(); send_byte(8'hC0);
    for (int i = 0; i < 5; i++) bit_out(1'b1);
    stb_high(); exp_err++;
    chk("err_partial", err_pulses, exp_err);
    frame1(8'h00); exp_err++;
    chk("err_cmd00", err_pulses, exp_err);
    chk("disp_keep", disp_on, 1); chk("bri_keep", brightness, 3);
    chk_idle_state("t5");

    // reset mid data byte, with fixed mode and display set beforehand
    frame1(8'h8F);
    chk("disp_on_8f", disp_on, 1); chk("bri_8f", brightness, 7);
    frame1(8'h44);
    push_wr(4'd5, 8'h77);
    stb_low(); send_byte(8'hC5); send_byte(8'h77);
    for (int i = 0; i < 4; i++) bit_out(i[0]);
    rst = 1'b1; wait_clk(3); rst = 1'b0; wait_clk(1);
    chk("mrst_oe", dio_oe, 0);    chk("mrst_dio", dio_o, 1);
    chk("mrst_we", ram_we, 0);    chk("mrst_addr", ram_addr, 0);
    chk("mrst_wdata", ram_wdata, 0); chk("mrst_disp", disp_on, 0);
    chk("mrst_bri", brightness, 0);  chk("mrst_ferr", frame_err, 0);
    for (int i = 0; i < 4; i++) bit_out(1'b0);
    send_byte(8'h99);
    stb_high();
    chk_idle_state("t6_ignore");
    // fresh frame: auto-increment is back after reset
    push_wr(4'd0, 8'h55); push_wr(4'd1, 8'h66);
    frame3(8'hC0, 8'h55, 8'h66);
    chk_idle_state("t6_fresh");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
